// File: rtl/nios2_dbg_ocimem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_dbg_ocimem_ctrl_if
//  Purpose  : CPU-side Avalon-MM slave bus of the debug-memory sequencer.
//             The CPU (master) holds address/strobes/data while waitrequest=1.
//  Revision : 1.0 - initial release
// ============================================================================
interface nios2_dbg_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/nios2_dbg_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_dbg_ocimem_ctrl
//  Purpose  : Debug-memory sequencer. Turns JTAG action pulses plus the jdo
//             payload into reads/writes of a DEPTHx32 debug RAM, returns read
//             data on MonDReg, and shares the RAM with a CPU Avalon slave.
//             JTAG always wins over the CPU; pulses that arrive while busy are
//             parked in a one-deep slot, and a pulse that finds the slot full
//             is lost and flagged on monitor_error.
//  Revision : 1.0 - initial release
// ============================================================================
module nios2_dbg_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [37:0]       jdo,
    input  wire logic              take_action_ocimem_a,
    input  wire logic              take_action_ocimem_b,
    input  wire logic              take_no_action_ocimem_a,
    output logic [31:0]            MonDReg,
    output logic                   monitor_ready,
    output logic                   monitor_error,
    nios2_dbg_ocimem_ctrl_if.slave cpu
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;   // accept JTAG / CPU work
    localparam logic [1:0] S_JRD  = 2'd1;   // JTAG read issued to RAM
    localparam logic [1:0] S_JCAP = 2'd2;   // capture RAM data into MonDReg
    localparam logic [1:0] S_CRD  = 2'd3;   // CPU read data presented

    // JTAG command codes
    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_A    = 2'd1;   // set address, optional read
    localparam logic [1:0] C_B    = 2'd2;   // write and increment
    localparam logic [1:0] C_N    = 2'd3;   // streaming read and increment

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend_valid;
    logic [1:0]        r_pend_cmd;
    logic [32:0]       r_pend_pay;          // jdo[35:3]: read flag + data/address
    logic [31:0]       r_ram_q;
    logic [31:0]       r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [1:0]        w_live_cmd;
    logic [32:0]       w_live_pay;
    logic              w_live_any;
    logic [1:0]        w_cmd;
    logic [32:0]       w_pay;
    logic [ADDR_W-1:0] w_new_addr;
    logic              w_drop;
    logic              w_park;
    logic              w_serve_pend;
    logic              w_unused;

    // Only jdo[35:3] carries meaning for the memory commands.
    assign w_unused   = &{1'b0, jdo[37:36], jdo[2:0]};
    assign w_live_pay = jdo[35:3];
    assign w_live_any = (w_live_cmd != C_NONE);

    // Map the three mutually exclusive pulses onto one command code.
    always_comb begin
        w_live_cmd = C_NONE;
        if (take_action_ocimem_a) begin
            w_live_cmd = C_A;
        end else if (take_action_ocimem_b) begin
            w_live_cmd = C_B;
        end else if (take_no_action_ocimem_a) begin
            w_live_cmd = C_N;
        end
    end

    // A parked command is always older than a live pulse, so it goes first.
    assign w_cmd        = r_pend_valid ? r_pend_cmd : w_live_cmd;
    assign w_pay        = r_pend_valid ? r_pend_pay : w_live_pay;
    assign w_new_addr   = w_pay[ADDR_W+13:14];          // jdo[ADDR_W+16:17]
    assign w_serve_pend = (r_state == S_IDLE) && r_pend_valid;
    assign w_drop       = w_live_any && r_pend_valid;
    assign w_park       = w_live_any && !r_pend_valid && (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: JTAG reads take the JRD/JCAP path, CPU reads take CRD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((w_cmd == C_N) || ((w_cmd == C_A) && w_pay[32])) begin
                    w_state_nxt = S_JRD;
                end else if ((w_cmd == C_NONE) && cpu.read) begin
                    w_state_nxt = S_CRD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_JRD:   w_state_nxt = S_JCAP;
            S_JCAP:  w_state_nxt = S_IDLE;
            S_CRD:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    logic              w_ram_rd;
    logic              w_ram_wr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_wdata;
    logic [3:0]        w_ram_be;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_err_clr;
    logic              w_ready_clr;
    logic              w_ready_set;
    logic              w_capture;
    logic              w_cpu_wait;

    // Per-state RAM access, address update and monitor flag control.
    always_comb begin
        w_ram_rd    = 1'b0;
        w_ram_wr    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = w_pay[31:0];
        w_ram_be    = 4'hF;
        w_addr_nxt  = r_addr;
        w_err_clr   = 1'b0;
        w_ready_clr = 1'b0;
        w_ready_set = 1'b0;
        w_capture   = 1'b0;
        w_cpu_wait  = 1'b1;
        case (r_state)
            S_IDLE: begin
                case (w_cmd)
                    C_A: begin
                        w_err_clr   = 1'b1;
                        w_ready_clr = 1'b1;
                        w_addr_nxt  = w_new_addr;
                        if (w_pay[32]) begin
                            w_ram_rd   = 1'b1;
                            w_ram_addr = w_new_addr;
                            w_addr_nxt = w_new_addr + 1'b1;
                        end
                    end
                    C_B: begin
                        w_ram_wr    = 1'b1;
                        w_addr_nxt  = r_addr + 1'b1;
                        w_ready_set = 1'b1;
                    end
                    C_N: begin
                        w_ram_rd    = 1'b1;
                        w_addr_nxt  = r_addr + 1'b1;
                        w_ready_clr = 1'b1;
                    end
                    default: begin
                        if (cpu.read) begin
                            w_ram_rd   = 1'b1;
                            w_ram_addr = cpu.address;
                        end else if (cpu.write) begin
                            // Writes complete in the cycle they are seen.
                            w_ram_wr    = 1'b1;
                            w_ram_addr  = cpu.address;
                            w_ram_wdata = cpu.writedata;
                            w_ram_be    = cpu.byteenable;
                            w_cpu_wait  = 1'b0;
                        end
                    end
                endcase
            end
            S_JCAP:  w_capture  = 1'b1;
            S_CRD:   w_cpu_wait = 1'b0;
            default: ;
        endcase
    end

    assign cpu.readdata    = r_ram_q;
    assign cpu.waitrequest = w_cpu_wait;

    // Address pointer; wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_addr_nxt;
        end
    end

    // One-deep slot for pulses that arrive while the sequencer is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= C_NONE;
            r_pend_pay   <= '0;
        end else if (w_serve_pend) begin
            r_pend_valid <= 1'b0;
        end else if (w_park) begin
            r_pend_valid <= 1'b1;
            r_pend_cmd   <= w_live_cmd;
            r_pend_pay   <= w_live_pay;
        end
    end

    // Monitor flags: a lost pulse outranks the clear done by an A command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_error <= 1'b0;
            monitor_ready <= 1'b0;
        end else begin
            if (w_drop) begin
                monitor_error <= 1'b1;
            end else if (w_err_clr) begin
                monitor_error <= 1'b0;
            end
            if (w_capture || w_ready_set) begin
                monitor_ready <= 1'b1;
            end else if (w_ready_clr) begin
                monitor_ready <= 1'b0;
            end
        end
    end

    // JTAG read data register, loaded in JCAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonDReg <= '0;
        end else if (w_capture) begin
            MonDReg <= r_ram_q;
        end
    end

    // RAM read port register; holds its value through JRD/JCAP and CRD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_q <= '0;
        end else if (w_ram_rd) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    // RAM array with byte-lane write enables; contents are never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_wr && w_ram_be[i]) begin
                r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
